// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC and hands one instruction at a time
// from instruction memory (req/ack) to decode (valid/ready), with redirect and halt.
module fetch_sequencer #(
  parameter int unsigned              ADDR_W     = 8,
  parameter int unsigned              INSTR_W    = 16,
  parameter logic [ADDR_W-1:0]        RESET_ADDR = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  output logic               halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  // Decoded straight from registers so an async reset drops the request at once.
  assign mem_req  = (state == FETCH);
  assign mem_addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      ir_valid <= 1'b0;
      ir_data  <= '0;
      ir_pc    <= '0;
      halted   <= 1'b0;
    end else if (redirect) begin
      // Flush wins over everything, including a completing fetch on this edge.
      state    <= IDLE;
      pc       <= redirect_addr;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ir_data  <= mem_rdata;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            if (halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state  <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM returns 16'hA000 + address.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        halt;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  fetch_sequencer #(.ADDR_W(8), .INSTR_W(16), .RESET_ADDR(8'h00)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .halt(halt), .halted(halted)
  );

  always #5 clock = ~clock;

  assign mem_rdata = 16'hA000 + {8'h00, mem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_addr = 8'h00; halt = 1'b0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h00);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir_data", 32'(ir_data), 32'h0000);
    chk("rst_ir_pc", 32'(ir_pc), 32'h00);
    chk("rst_halted", 32'(halted), 32'd0);
    #10 reset = 1'b1;
    #1 chk("idle_mem_req", 32'(mem_req), 32'd0);
    step();
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h00);

    // Back-to-back: one instruction every two cycles
    mem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_valid", 32'(ir_valid), 32'd1);
      chk("t1_ir_pc", 32'(ir_pc), 32'(i));
      chk("t1_ir_data", 32'(ir_data), 32'hA000 + 32'(i));
      chk("t1_req_low", 32'(mem_req), 32'd0);
      step();
      chk("t1_valid_low", 32'(ir_valid), 32'd0);
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_addr", 32'(mem_addr), 32'(i + 1));
    end

    // Slow memory, then slow decode
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req_wait", 32'(mem_req), 32'd1);
      chk("t2_addr_wait", 32'(mem_addr), 32'h04);
    end
    mem_ack = 1'b1; ir_ready = 1'b0;
    step();
    chk("t2_ir_pc", 32'(ir_pc), 32'h04);
    chk("t2_ir_data", 32'(ir_data), 32'hA004);
    chk("t2_pc_inc_once", 32'(mem_addr), 32'h05);
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", 32'(ir_valid), 32'd1);
      chk("t2_hold_data", 32'(ir_data), 32'hA004);
      chk("t2_hold_pc", 32'(ir_pc), 32'h04);
      chk("t2_hold_req", 32'(mem_req), 32'd0);
    end
    ir_ready = 1'b1;
    step();
    chk("t2_release", 32'(ir_valid), 32'd0);
    chk("t2_next_addr", 32'(mem_addr), 32'h05);

    // Redirect while holding 8'h05
    mem_ack = 1'b1; ir_ready = 1'b0;
    step();
    chk("t3_hold_pc", 32'(ir_pc), 32'h05);
    chk("t3_hold_valid", 32'(ir_valid), 32'd1);
    mem_ack = 1'b0; redirect = 1'b1; redirect_addr = 8'h40;
    step();
    redirect = 1'b0;
    chk("t3_flush", 32'(ir_valid), 32'd0);
    chk("t3_req_gap", 32'(mem_req), 32'd0);
    step();
    chk("t3_req", 32'(mem_req), 32'd1);
    chk("t3_addr", 32'(mem_addr), 32'h40);
    chk("t3_no_valid", 32'(ir_valid), 32'd0);

    // Redirect on the same edge as mem_ack
    mem_ack = 1'b1; redirect = 1'b1; redirect_addr = 8'h10;
    step();
    redirect = 1'b0;
    chk("t4_drop_valid", 32'(ir_valid), 32'd0);
    chk("t4_addr", 32'(mem_addr), 32'h10);
    step();
    chk("t4_fetch_addr", 32'(mem_addr), 32'h10);
    chk("t4_fetch_req", 32'(mem_req), 32'd1);
    chk("t4_still_no_valid", 32'(ir_valid), 32'd0);
    step();
    chk("t4_ir_pc", 32'(ir_pc), 32'h10);
    chk("t4_ir_data", 32'(ir_data), 32'hA010);
    mem_ack = 1'b0; ir_ready = 1'b1;
    step();
    chk("t4_next", 32'(mem_addr), 32'h11);

    // PC wrap at 8'hFF
    redirect = 1'b1; redirect_addr = 8'hFF;
    step();
    redirect = 1'b0;
    step();
    chk("t5_addr_ff", 32'(mem_addr), 32'hFF);
    mem_ack = 1'b1; ir_ready = 1'b0;
    step();
    chk("t5_ir_pc", 32'(ir_pc), 32'hFF);
    chk("t5_ir_data", 32'(ir_data), 32'hA0FF);
    chk("t5_wrap", 32'(mem_addr), 32'h00);
    mem_ack = 1'b0; ir_ready = 1'b1;
    step();
    chk("t5_wrap_req", 32'(mem_req), 32'd1);
    chk("t5_wrap_addr", 32'(mem_addr), 32'h00);

    // Halt during fetch of 8'h03
    redirect = 1'b1; redirect_addr = 8'h03;
    step();
    redirect = 1'b0;
    step();
    chk("t6_addr", 32'(mem_addr), 32'h03);
    halt = 1'b1;
    step();
    chk("t6_halt_ign", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    step();
    chk("t6_deliver", 32'(ir_pc), 32'h03);
    chk("t6_deliver_v", 32'(ir_valid), 32'd1);
    chk("t6_not_halted", 32'(halted), 32'd0);
    halt = 1'b0;
    // halt must be resampled on the handshake edge, so re-raise it
    halt = 1'b1; mem_ack = 1'b0;
    step();
    halt = 1'b0;
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_halt_req", 32'(mem_req), 32'd0);
    chk("t6_halt_valid", 32'(ir_valid), 32'd0);
    mem_ack = 1'b1;
    step();
    step();
    chk("t6_stay_halted", 32'(halted), 32'd1);
    chk("t6_pc_frozen", 32'(mem_addr), 32'h04);
    chk("t6_stay_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0; redirect = 1'b1; redirect_addr = 8'h20;
    step();
    redirect = 1'b0;
    chk("t6_unhalt", 32'(halted), 32'd0);
    step();
    chk("t6_fetch20_req", 32'(mem_req), 32'd1);
    chk("t6_fetch20_addr", 32'(mem_addr), 32'h20);

    // Redirect and halt together: redirect wins, halt taken in IDLE
    redirect = 1'b1; redirect_addr = 8'h30; halt = 1'b1;
    step();
    redirect = 1'b0;
    chk("t7_redir_wins", 32'(halted), 32'd0);
    chk("t7_addr", 32'(mem_addr), 32'h30);
    step();
    halt = 1'b0;
    chk("t7_halted", 32'(halted), 32'd1);
    chk("t7_no_req", 32'(mem_req), 32'd0);
    redirect = 1'b1; redirect_addr = 8'h50;
    step();
    redirect = 1'b0;
    step();
    chk("t7_fetch50", 32'(mem_addr), 32'h50);
    chk("t7_fetch50_req", 32'(mem_req), 32'd1);

    // Async reset mid-fetch, no clock edge in between
    reset = 1'b0;
    #1;
    chk("t8_req_drop", 32'(mem_req), 32'd0);
    chk("t8_pc_reset", 32'(mem_addr), 32'h00);
    chk("t8_valid", 32'(ir_valid), 32'd0);
    chk("t8_ir_data", 32'(ir_data), 32'h0000);
    chk("t8_halted", 32'(halted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
